// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, IF/ID pipeline register, RUN/HALT control
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic [31:0] INST_IN,
    output logic [31:0] ADDR,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_INST,
    output logic        IF_ID_VALID,
    output logic        HALTED,
    output logic [31:0] FETCH_CNT
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] if_id_pc_next;
    logic [31:0] if_id_inst_next;
    logic        if_id_valid_next;
    logic [31:0] fetch_cnt_next;

    assign ADDR   = pc;
    assign HALTED = (state == HALT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            pc          <= RESET_PC;
            IF_ID_PC    <= 32'h0;
            IF_ID_INST  <= NOP_INST;
            IF_ID_VALID <= 1'b0;
            FETCH_CNT   <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            IF_ID_PC    <= if_id_pc_next;
            IF_ID_INST  <= if_id_inst_next;
            IF_ID_VALID <= if_id_valid_next;
            FETCH_CNT   <= fetch_cnt_next;
        end
    end

    // A redirect always wins, even out of HALT: the halt may sit behind an older branch.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        if_id_pc_next    = IF_ID_PC;
        if_id_inst_next  = IF_ID_INST;
        if_id_valid_next = IF_ID_VALID;
        fetch_cnt_next   = FETCH_CNT;
        if (BR_TAKEN) begin
            state_next       = RUN;
            pc_next          = {BR_TARGET[31:2], 2'b00};
            if_id_pc_next    = pc;
            if_id_inst_next  = NOP_INST;
            if_id_valid_next = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!STALL) begin
                        if (INST_IN != 32'h0) begin
                            pc_next          = pc + 32'd4;
                            if_id_pc_next    = pc;
                            if_id_inst_next  = INST_IN;
                            if_id_valid_next = 1'b1;
                            fetch_cnt_next   = FETCH_CNT + 32'd1;
                        end else begin
                            state_next       = HALT;
                            if_id_inst_next  = NOP_INST;
                            if_id_valid_next = 1'b0;
                        end
                    end
                end
                HALT: begin
                    if_id_inst_next  = NOP_INST;
                    if_id_valid_next = 1'b0;
                end
                default: state_next = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage over a bubble-sort instruction image
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] BR_TARGET = 32'h0;
    logic [31:0] INST_IN;
    logic [31:0] ADDR;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_INST;
    logic        IF_ID_VALID;
    logic        HALTED;
    logic [31:0] FETCH_CNT;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc, m_ipc, m_inst, m_cnt;
    logic        m_valid, m_halt;
    logic [31:0] prog [0:21];

    if_stage dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
        .BR_TARGET(BR_TARGET), .INST_IN(INST_IN), .ADDR(ADDR),
        .IF_ID_PC(IF_ID_PC), .IF_ID_INST(IF_ID_INST), .IF_ID_VALID(IF_ID_VALID),
        .HALTED(HALTED), .FETCH_CNT(FETCH_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a < 32'd88) return prog[a[6:2]];
        return 32'h00100093;
    endfunction

    assign INST_IN = mem_read(ADDR);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
        logic [31:0] w;
        w = mem_read(m_pc);
        if (rst) begin
            m_pc = 32'h0; m_halt = 1'b0; m_ipc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_cnt = 32'h0;
        end else if (br) begin
            m_ipc = m_pc; m_pc = {tgt[31:2], 2'b00}; m_inst = NOP; m_valid = 1'b0; m_halt = 1'b0;
        end else if (m_halt || st) begin
            // hold everything
        end else if (w != 32'h0) begin
            m_ipc = m_pc; m_inst = w; m_valid = 1'b1; m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
        end else begin
            m_halt = 1'b1; m_inst = NOP; m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
        exp_t e;
        @(negedge CLK);
        RST = rst; STALL = st; BR_TAKEN = br; BR_TARGET = tgt;
        model_edge(rst, st, br, tgt);
        e.addr = m_pc; e.ipc = m_ipc; e.inst = m_inst; e.valid = m_valid; e.halted = m_halt; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check("addr", ADDR, e.addr);
        check("if_id_pc", IF_ID_PC, e.ipc);
        check("if_id_inst", IF_ID_INST, e.inst);
        check("if_id_valid", {31'b0, IF_ID_VALID}, {31'b0, e.valid});
        check("halted", {31'b0, HALTED}, {31'b0, e.halted});
        check("fetch_cnt", FETCH_CNT, e.cnt);
    endtask

    task automatic run_to_halt(input string tag);
        int n;
        n = 0;
        while (!HALTED && n < 60) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n++;
        end
        check(tag, {31'b0, HALTED}, 32'd1);
    endtask

    initial begin
        logic [31:0] cnt_save;
        prog = '{32'h00400713, 32'h00900593, 32'h00000613, 32'h00b65e63,
                 32'h00000693, 32'h40c586b3, 32'hfff68693, 32'h00000793,
                 32'h00279813, 32'h01070833, 32'h00082883, 32'h00482903,
                 32'h01195663, 32'h01282023, 32'h01182223, 32'h00178793,
                 32'hfcd7cae3, 32'h00160613, 32'hfb9ff06f, 32'h00100513,
                 32'h00a02023, 32'h00000000};
        m_pc = 0; m_ipc = 0; m_inst = NOP; m_valid = 0; m_halt = 0; m_cnt = 0;

        step(1'b1, 1'b1, 1'b1, 32'h40);
        check("reset_addr", ADDR, 32'h0);
        check("reset_cnt", FETCH_CNT, 32'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("first_inst", IF_ID_INST, 32'h00400713);
        check("first_pc", IF_ID_PC, 32'h0);
        check("first_addr", ADDR, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("second_inst", IF_ID_INST, 32'h00900593);
        check("second_cnt", FETCH_CNT, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_stall_addr", ADDR, 32'd16);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_addr", ADDR, 32'd16);
        check("stall_cnt", FETCH_CNT, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("release_pc", IF_ID_PC, 32'd16);
        check("release_addr", ADDR, 32'd20);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("at60", ADDR, 32'd60);
        cnt_save = FETCH_CNT;
        step(1'b0, 1'b1, 1'b1, 32'd28);
        check("br28_addr", ADDR, 32'd28);
        check("br28_inst", IF_ID_INST, NOP);
        check("br28_cnt", FETCH_CNT, cnt_save);
        step(1'b0, 1'b1, 1'b1, 32'd31);
        check("br31_addr", ADDR, 32'd28);

        run_to_halt("halt_reached_1");
        check("halt_addr", ADDR, 32'd84);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("halt_hold_addr", ADDR, 32'd84);
        step(1'b0, 1'b0, 1'b1, 32'd72);
        check("unhalt", {31'b0, HALTED}, 32'd0);
        check("unhalt_addr", ADDR, 32'd72);

        step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", ADDR, 32'h0);
        check("wrap_pc", IF_ID_PC, 32'hFFFFFFFC);

        run_to_halt("halt_reached_2");
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_halt_cnt", FETCH_CNT, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'd40);
        check("rst_br_addr", ADDR, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 90);
            step($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 12) == 0, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h00000013, bubble word (addi x0,x0,0) inserted on flush.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 STALL  input  1  hazard hold from downstream; freezes PC and IF/ID register.
REQ-006 BR_TAKEN  input  1  branch/jump resolved taken this cycle; redirect plus flush.
REQ-007 BR_TARGET  input  32  redirect byte address.
REQ-008 INST_IN  input  32  instruction word returned combinationally by the instruction memory for ADDR.
REQ-009 ADDR  output  32  fetch byte address driven to the instruction memory.
REQ-010 IF_ID_PC  output  32  registered PC of the latched instruction.
REQ-011 IF_ID_INST  output  32  registered instruction word for decode.
REQ-012 IF_ID_VALID  output  1  IF_ID_INST is a real fetched instruction, not a bubble.
REQ-013 HALTED  output  1  high while the FSM is in HALT.
REQ-014 FETCH_CNT  output  32  count of valid instructions delivered to IF/ID.

Function
REQ-015 ADDR SHALL equal the internal PC register combinationally; no extra latency to the memory.
REQ-016 An instruction presented at ADDR in cycle N SHALL appear on IF_ID_INST/IF_ID_PC after the rising edge ending cycle N (1-cycle fetch latency).
REQ-017 FSM states: RUN, HALT; RUN SHALL be entered on reset.
REQ-018 RUN, per-edge priority: BR_TAKEN > STALL > normal advance.
REQ-019 RUN, BR_TAKEN=1: PC <= {BR_TARGET[31:2],2'b00}; IF_ID_INST <= NOP_INST; IF_ID_VALID <= 0; IF_ID_PC <= PC; regardless of STALL.
REQ-020 RUN, STALL=1, BR_TAKEN=0: PC, IF_ID_PC, IF_ID_INST, IF_ID_VALID, FETCH_CNT SHALL hold.
REQ-021 RUN, normal advance with INST_IN != 0: PC <= PC+4; IF_ID_PC <= PC; IF_ID_INST <= INST_IN; IF_ID_VALID <= 1; FETCH_CNT <= FETCH_CNT+1.
REQ-022 RUN, normal advance with INST_IN == 32'h0 (end of program): transition to HALT; PC holds; IF_ID_INST <= NOP_INST; IF_ID_VALID <= 0; FETCH_CNT holds.
REQ-023 HALT: PC, FETCH_CNT hold; IF_ID_VALID SHALL be 0, IF_ID_INST NOP_INST; STALL ignored.
REQ-024 HALT, BR_TAKEN=1: redirect per REQ-019 and return to RUN (halt was speculative behind an older branch).
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000) with no flag.
REQ-026 FETCH_CNT SHALL wrap modulo 2^32.
REQ-027 BR_TARGET[1:0] SHALL be ignored (forced 0); no misalignment exception.
REQ-028 HALTED SHALL be 1 exactly when state is HALT.

Reset
REQ-029 On RST=1 at a rising edge, regardless of all other inputs: PC <= RESET_PC; state <= RUN; IF_ID_PC <= 0; IF_ID_INST <= NOP_INST; IF_ID_VALID <= 0; FETCH_CNT <= 0; HALTED = 0.
REQ-030 RST asserted mid-operation (including during STALL, BR_TAKEN or HALT) SHALL take effect on that edge with no residual state.

Verification
REQ-031 Reset then run with instruction memory holding the bubble-sort program -> ADDR=0 first cycle; after edge 1 IF_ID_INST=32'h00400713, IF_ID_PC=0, IF_ID_VALID=1, ADDR=4; after edge 2 IF_ID_INST=32'h00900593, FETCH_CNT=2.
REQ-032 STALL=1 for 3 cycles while ADDR=16 -> ADDR stays 16, IF/ID outputs and FETCH_CNT unchanged; on release next edge IF_ID_PC=16, ADDR=20.
REQ-033 BR_TAKEN=1, BR_TARGET=28 (also BR_TARGET=31) while ADDR=60, STALL=1 -> next edge ADDR=28, IF_ID_VALID=0, IF_ID_INST=32'h00000013, FETCH_CNT unchanged.
REQ-034 Sequential run reaching ADDR=84 (INST_IN=0) -> HALTED=1, ADDR holds 84, IF_ID_VALID=0; then BR_TAKEN=1, BR_TARGET=72 -> HALTED=0, ADDR=72 next edge.
REQ-035 Force PC to 32'hFFFFFFFC via BR_TARGET, INST_IN nonzero, advance -> ADDR=0 next edge, IF_ID_PC=32'hFFFFFFFC.
REQ-036 RST=1 during HALT and during BR_TAKEN=1 -> ADDR=RESET_PC, FETCH_CNT=0, IF_ID_VALID=0, HALTED=0 after that edge.
